// File: rtl/cpu_pkg.sv
// Shared CPU parameters and issue payload, common to operand fetch and register file.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_NUM    = 8;
    localparam int unsigned DATA_W     = 32;

    // Operand bundle handed to the execute stage
    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     b;
        logic [DATA_W-1:0]     a;
    } op_payload_t;

    // One-hot mask selecting a single register
    function automatic logic [REG_NUM-1:0] idx_mask(input logic [REG_ADDR_W-1:0] idx);
        logic [REG_NUM-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue of a writing op, cleared on writeback; set wins.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [REG_NUM-1:0]    busy
);

    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;

    // Decode set/clear requests into bit masks
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask = idx_mask(set_idx);
        if (clr_en) clr_mask = idx_mask(clr_idx);
    end

    // Clear first, then set, so a same-cycle set on the same bit survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboard hazard check, register read with writeback forwarding,
// one-entry output register toward execute.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_ADDR_W-1:0] req_src1,
    input  logic [REG_ADDR_W-1:0] req_src2,
    input  logic [REG_ADDR_W-1:0] req_dst,
    input  logic                  req_wen,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_W-1:0]     op_a,
    output logic [DATA_W-1:0]     op_b,
    output logic [REG_ADDR_W-1:0] op_dst,
    output logic                  op_wen,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] ra1,
    output logic [REG_ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0]     rd1,
    input  logic [DATA_W-1:0]     rd2,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [DATA_W-1:0]     wd,
    output logic                  we,
    output logic                  idle
);

    logic [REG_NUM-1:0] busy;
    logic               fwd1;
    logic               fwd2;
    logic               haz1;
    logic               haz2;
    logic               accept;
    op_payload_t        op_q;
    op_payload_t        op_d;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && req_wen),
        .set_idx (req_dst),
        .clr_en  (wb_valid),
        .clr_idx (wb_addr),
        .busy    (busy)
    );

    // Register-file read/write ports are pure pass-through, reset does not gate them
    assign ra1 = req_src1;
    assign ra2 = req_src2;
    assign we  = wb_valid;
    assign wa  = wb_addr;
    assign wd  = wb_data;

    // Hazard detection, issue handshake and forwarded operand selection
    always_comb begin
        fwd1        = wb_valid && (wb_addr == req_src1);
        fwd2        = wb_valid && (wb_addr == req_src2);
        haz1        = busy[req_src1] && !fwd1;
        haz2        = busy[req_src2] && !fwd2;
        req_ready   = (!op_valid || op_ready) && !haz1 && !haz2;
        accept      = req_valid && req_ready;
        op_d.a      = fwd1 ? wb_data : rd1;
        op_d.b      = fwd2 ? wb_data : rd2;
        op_d.dst    = req_dst;
        op_d.wen    = req_wen;
        idle        = (busy == '0) && !op_valid;
    end

    // Output register: load on accept, drop valid once consumed, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid <= 1'b0;
            op_q     <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_q     <= op_d;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

    assign op_a   = op_q.a;
    assign op_b   = op_q.b;
    assign op_dst = op_q.dst;
    assign op_wen = op_q.wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register-file/busy model.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_src1, req_src2, req_dst;
    logic        op_valid, op_ready, op_wen;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_dst;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we, idle;

    logic [31:0] rf [8];

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [31:0] m_rf [8];
    logic [7:0]  m_busy;
    logic        m_opv;
    op_payload_t exp_q [$];

    always #5 clk = ~clk;

    // register file slave: combinational read, write on rising edge
    always @(posedge clk) if (we) rf[wa] <= wd;
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    operand_fetch u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wen(req_wen),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_dst(op_dst), .op_wen(op_wen),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa(wa), .wd(wd), .we(we), .idle(idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // One clock of stimulus; model predicts handshake and operands from register contents
    task automatic step(input logic rv, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic w, input logic ordy,
                        input logic wbv, input logic [2:0] wba, input logic [31:0] wbd);
        logic h1, h2, mrdy, acc;
        op_payload_t e;
        @(negedge clk);
        req_valid = rv; req_src1 = s1; req_src2 = s2; req_dst = d; req_wen = w;
        op_ready = ordy; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
        #1;
        h1   = m_busy[s1] && !(wbv && wba == s1);
        h2   = m_busy[s2] && !(wbv && wba == s2);
        mrdy = (!m_opv || ordy) && !h1 && !h2;
        acc  = rv && mrdy;
        chk("req_ready", 64'(req_ready), 64'(mrdy));
        chk("idle", 64'(idle), 64'((m_busy == 8'h00) && !m_opv));
        chk("op_valid", 64'(op_valid), 64'(m_opv));
        chk("busy", 64'(u_dut.busy), 64'(m_busy));
        chk("read_addr", 64'({ra1, ra2}), 64'({s1, s2}));
        chk("wb_pass", 64'({we, wa, wd}), 64'({wbv, wba, wbd}));
        if (wbv) m_rf[wba] = wbd;
        if (acc) begin
            e.a = m_rf[s1]; e.b = m_rf[s2]; e.dst = d; e.wen = w;
            exp_q.push_back(e);
        end
        if (wbv) m_busy[wba] = 1'b0;
        if (acc && w) m_busy[d] = 1'b1;
        m_opv = acc ? 1'b1 : (ordy ? 1'b0 : m_opv);
    endtask

    task automatic idle_step(input logic ordy);
        step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, ordy, 1'b0, 3'd0, 32'h0);
    endtask

    // Monitor: compare on each output handshake, and check operands hold while stalled
    initial begin
        op_payload_t e, held;
        logic stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst || !op_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk("op_hold", 64'({op_wen, op_dst, op_a}) ^ 64'(op_b),
                        64'({held.wen, held.dst, held.a}) ^ 64'(held.b));
                if (op_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_op", 64'(op_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("op_a", 64'(op_a), 64'(e.a));
                        chk("op_b", 64'(op_b), 64'(e.b));
                        chk("op_dst_wen", 64'({op_dst, op_wen}), 64'({e.dst, e.wen}));
                    end
                end else begin
                    stalled = 1'b1;
                    held.a = op_a; held.b = op_b; held.dst = op_dst; held.wen = op_wen;
                end
            end
        end
    end

    initial begin
        req_valid = 0; req_src1 = 0; req_src2 = 0; req_dst = 0; req_wen = 0;
        op_ready = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        m_busy = 8'h00; m_opv = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset_outputs", 64'({op_valid, op_wen, op_dst}), 64'(0));
        chk("reset_operands", {op_a, op_b}, 64'(0));
        chk("reset_idle_ready", 64'({idle, req_ready}), 64'(2'b11));

        // preload register file through writeback while in reset
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_addr = 3'(i); wb_data = 32'h11 * 32'(i);
            m_rf[i] = 32'h11 * 32'(i);
            #1 chk("we_in_reset", 64'({we, wa}), 64'({1'b1, 3'(i)}));
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #2 rst = 1'b1;

        // basic read: r1=0x11, r2=0x22
        step(1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        idle_step(1'b1);

        // RAW stall on r3 resolved by forwarded writeback
        step(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd3, 3'd1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd3, 3'd1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd3, 3'd1, 3'd4, 1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_ABCD);
        idle_step(1'b1);

        // downstream stall for 3 cycles, then release with same-cycle accept
        step(1'b1, 3'd1, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd2, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd2, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        idle_step(1'b1);

        // set wins over same-cycle clear on r5
        step(1'b1, 3'd0, 3'd1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 32'h5555_0005);
        step(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        chk("set_wins_busy5", 64'(u_dut.busy[5]), 64'(1));
        step(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd5, 32'h0505_5050);
        idle_step(1'b1);

        // build busy=0x0C with a stalled op, then asynchronous reset mid-cycle
        step(1'b1, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd1, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        idle_step(1'b0);
        @(negedge clk);
        req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete();
        m_busy = 8'h00; m_opv = 1'b0;
        #1;
        chk("async_reset_busy", 64'(u_dut.busy), 64'(0));
        chk("async_reset_valid_idle", 64'({op_valid, idle, req_ready}), 64'(3'b011));
        chk("async_reset_payload", {op_a, op_b}, 64'(0));
        #9 rst = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom);

        // drain outstanding ops and pending writes
        for (int i = 0; i < 8; i++)
            step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'(i), 32'h1000 + 32'(i));
        idle_step(1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("final_idle", 64'(idle), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
